// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS hazard/stall logic.
package mips_hazard_pkg;

    localparam int REG_W = 5;

    // Number of stall cycles a hazard requires (0, 1 or 2).
    typedef logic [1:0] need_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_need_calc.sv
// Combinational computation of how many stall cycles the instruction in ID
// needs, given the producers sitting in EX and MEM.
module hazard_need_calc
    import mips_hazard_pkg::*;
(
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterDst,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_RegisterRd,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    output need_t            need
);

    logic rt_used;
    logic ex_match;
    logic mem_match;

    // Source/destination matching; register $0 never creates a dependency,
    // and Rt only counts when the ID instruction actually reads it.
    always_comb begin
        rt_used   = IF_ID_UsesRt | IF_ID_Branch;
        ex_match  = (ID_EX_RegisterDst != '0) &&
                    ((ID_EX_RegisterDst == IF_ID_RegisterRs) ||
                     (rt_used && (ID_EX_RegisterDst == IF_ID_RegisterRt)));
        mem_match = (EX_MEM_RegisterRd != '0) &&
                    ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                     (rt_used && (EX_MEM_RegisterRd == IF_ID_RegisterRt)));
    end

    // Worst-case stall count; branches resolve in ID so they wait longer.
    always_comb begin
        need = 2'd0;
        if (IF_ID_Branch) begin
            if (ID_EX_MemRead && ex_match) begin
                need = 2'd2;
            end else if ((ID_EX_RegWrite && !ID_EX_MemRead && ex_match) ||
                         (EX_MEM_MemRead && mem_match)) begin
                need = 2'd1;
            end
        end else if (ID_EX_MemRead && ex_match) begin
            need = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall controller: turns the required stall count into
// PC/IF-ID enables, ID/EX bubbles and taken-branch flushes.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import mips_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterDst,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_RegisterRd,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    state_t state_q, state_d;
    logic   cnt_q, cnt_d;
    need_t  need;

    hazard_need_calc u_need (
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_RegisterDst (ID_EX_RegisterDst),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
        .IF_ID_RegisterRs  (IF_ID_RegisterRs),
        .IF_ID_RegisterRt  (IF_ID_RegisterRt),
        .IF_ID_UsesRt      (IF_ID_UsesRt),
        .IF_ID_Branch      (IF_ID_Branch),
        .need              (need)
    );

    // State and remaining-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and outputs; an external freeze overrides everything and
    // discards any hazard seen in that cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        if (reset) begin
            state_d = RUN;
            cnt_d   = 1'b0;
        end else if (ext_stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (need != 2'd0) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                        if (need == 2'd2) begin
                            cnt_d   = 1'b1;
                            state_d = STALL;
                        end
                    end else if (IF_ID_Branch && branch_taken) begin
                        IF_ID_flush = 1'b1;
                    end
                end
                STALL: begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    if (cnt_q) begin
                        cnt_d = 1'b0;
                    end
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of bubble cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (ID_EX_bubble && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = reset ? 16'd0 : stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push their
// hand-computed outputs into a queue, a monitor pops and compares each cycle.
module tb_hazard_stall_unit;
    import mips_hazard_pkg::*;

    typedef struct {
        logic       rst;
        logic       mr;
        logic       rw;
        logic [4:0] dst;
        logic       emr;
        logic [4:0] emrd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       br;
        logic       tk;
        logic       ext;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        int         idx;
        logic       rst;
        logic [3:0] exp;
    } exp_t;

    // Expected {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush}.
    localparam logic [3:0] N = 4'b1100;
    localparam logic [3:0] S = 4'b0010;
    localparam logic [3:0] F = 4'b0000;
    localparam logic [3:0] L = 4'b1101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ID_EX_MemRead = 1'b0, ID_EX_RegWrite = 1'b0, EX_MEM_MemRead = 1'b0;
    logic [4:0] ID_EX_RegisterDst = '0, EX_MEM_RegisterRd = '0;
    logic [4:0] IF_ID_RegisterRs = '0, IF_ID_RegisterRt = '0;
    logic IF_ID_UsesRt = 1'b0, IF_ID_Branch = 1'b0, branch_taken = 1'b0, ext_stall = 1'b0;
    logic PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] modelCnt = 16'd0;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    exp_t sb[$];
    vec_t vecs[$];

    hazard_stall_unit dut (
        .clk               (clk),
        .reset             (reset),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_RegisterDst (ID_EX_RegisterDst),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
        .IF_ID_RegisterRs  (IF_ID_RegisterRs),
        .IF_ID_RegisterRt  (IF_ID_RegisterRt),
        .IF_ID_UsesRt      (IF_ID_UsesRt),
        .IF_ID_Branch      (IF_ID_Branch),
        .branch_taken      (branch_taken),
        .ext_stall         (ext_stall),
        .PC_write          (PC_write),
        .IF_ID_write       (IF_ID_write),
        .ID_EX_bubble      (ID_EX_bubble),
        .IF_ID_flush       (IF_ID_flush)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic mr, input logic rw,
                                input logic [4:0] dst, input logic emr,
                                input logic [4:0] emrd, input logic [4:0] rs,
                                input logic [4:0] rt, input logic ur,
                                input logic br, input logic tk, input logic ext,
                                input logic [3:0] exp);
        vec_t v;
        v.rst = rst; v.mr = mr; v.rw = rw; v.dst = dst; v.emr = emr; v.emrd = emrd;
        v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.tk = tk; v.ext = ext; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = v.rst;
        ID_EX_MemRead     = v.mr;
        ID_EX_RegWrite    = v.rw;
        ID_EX_RegisterDst = v.dst;
        EX_MEM_MemRead    = v.emr;
        EX_MEM_RegisterRd = v.emrd;
        IF_ID_RegisterRs  = v.rs;
        IF_ID_RegisterRt  = v.rt;
        IF_ID_UsesRt      = v.ur;
        IF_ID_Branch      = v.br;
        branch_taken      = v.tk;
        ext_stall         = v.ext;
        e.idx = idx;
        e.rst = v.rst;
        e.exp = v.exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] act;
        act = {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush};
        testsRun++;
        if (act !== e.exp) begin
            testsFailed++;
            $display("[TB] FAIL vec%0d outputs: got %b expected %b", e.idx, act, e.exp);
        end
`ifdef HAZARD_PERF_CNT_EN
        testsRun++;
        if (stall_cycles !== (e.rst ? 16'd0 : modelCnt)) begin
            testsFailed++;
            $display("[TB] FAIL vec%0d stall_cycles: got %0d expected %0d",
                     e.idx, stall_cycles, e.rst ? 16'd0 : modelCnt);
        end
        if (e.rst) modelCnt = 16'd0;
        else if (e.exp[1] && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
`endif
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        //            rst mr rw dst emr emrd rs rt ur br tk ext exp
        vecs.push_back(mk(1, 1, 0, 5, 0, 0, 5, 0, 0, 0, 0, 0, N)); // reset forces defaults
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N)); // idle
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 5, 0, 0, 0, 0, 0, S)); // load-use on Rs
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, N)); // exactly one cycle
        vecs.push_back(mk(0, 1, 0, 7, 0, 0, 1, 7, 0, 0, 0, 0, N)); // Rt ignored
        vecs.push_back(mk(0, 1, 0, 7, 0, 0, 1, 7, 1, 0, 0, 0, S)); // Rt used
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N)); // $0 never stalls
        vecs.push_back(mk(0, 1, 0, 8, 0, 0, 1, 8, 0, 1, 1, 0, S)); // branch after load
        vecs.push_back(mk(0, 1, 0, 8, 0, 0, 1, 8, 0, 1, 1, 0, S)); // second stall, no flush
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 1, 8, 0, 1, 1, 0, S)); // branch on MEM load
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 0, 1, 1, 0, L)); // taken branch flush
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 0, 1, 0, 0, N)); // not taken
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 3, 0, 0, 1, 0, 0, S)); // branch on ALU result
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 3, 0, 0, 1, 0, 1, F)); // ext_stall wins
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, F)); // flush blocked
        vecs.push_back(mk(0, 1, 0, 8, 0, 0, 1, 8, 0, 1, 0, 1, F)); // hazard not committed
        vecs.push_back(mk(0, 1, 0, 8, 0, 0, 1, 8, 0, 1, 0, 0, S)); // enter STALL
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, F)); // STALL held
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S)); // STALL completes
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));
        vecs.push_back(mk(0, 1, 0, 8, 0, 0, 1, 8, 0, 1, 0, 0, S)); // enter STALL
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N)); // reset mid-STALL
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N)); // back in RUN
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 0, 0, N)); // MEM load, non-branch
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, N)); // branch, dst $0
        vecs.push_back(mk(0, 0, 1, 6, 0, 0, 6, 0, 0, 0, 0, 0, N)); // ALU producer, non-branch
        // Three load-use events and one branch-after-load from a clean count.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(0, 1, 0, 9, 0, 0, 9, 0, 0, 0, 0, 0, S));
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, N));
        end
        vecs.push_back(mk(0, 1, 0, 10, 0, 0, 10, 0, 0, 1, 0, 0, S));
        vecs.push_back(mk(0, 1, 0, 10, 0, 0, 10, 0, 0, 1, 0, 0, S));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        #1;
        testsRun++;
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        testsRun++;
        if (stall_cycles !== 16'd5) begin
            testsFailed++;
            $display("[TB] FAIL perf_total: got %0d expected 5", stall_cycles);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
